// File: rtl/pc_seq.sv
// pc_seq: parametrised fetch-stage program counter with stall, buffered redirect, halt and exception entry/return.
//
// Optional feature macro: PC_SEQ_ICNT_EN (adds the icnt_o issued-fetch counter).
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   stall_i       fetch hold; pc must not advance
//   br_en_i       PC-relative branch taken, target pc_inc + br_imm_i
//   br_imm_i      sign-extended branch displacement
//   jr_en_i       register-indirect jump taken, target rs_i + imm_i
//   rs_i, imm_i   jump base register and sign-extended offset
//   halt_i        enter the HALTED state (left only by reset)
//   siic_i        exception request, target EXC_VEC, saves pc_inc in epc
//   rti_i         return from exception, target epc
//   pc_o          registered fetch address
//   pc_inc_o      pc_o + INC
//   fetch_valid_o pc_o is a valid fetch address this cycle
//   halted_o      block is HALTED
//   epc_o         saved exception return address
//   redir_pend_o  a redirect is buffered awaiting stall release
//   icnt_o        (PC_SEQ_ICNT_EN only) count of issued fetches
module pc_seq #(
    parameter int unsigned     AW        = 16,
    parameter int unsigned     INC       = 2,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter logic [AW-1:0]   EXC_VEC   = AW'(2)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stall_i,
    input  logic          br_en_i,
    input  logic [AW-1:0] br_imm_i,
    input  logic          jr_en_i,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] imm_i,
    input  logic          halt_i,
    input  logic          siic_i,
    input  logic          rti_i,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc_inc_o,
    output logic          fetch_valid_o,
    output logic          halted_o,
    output logic [AW-1:0] epc_o,
    output logic          redir_pend_o
`ifdef PC_SEQ_ICNT_EN
    ,
    output logic [31:0]   icnt_o
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, epc_q, epc_d, pend_addr_q, pend_addr_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pc_inc, tgt;
    logic          take_halt, redir;
    assign pc_inc = pc_q + AW'(INC);
    // halt sits between rti and jr in priority, so it masks only jr/br
    assign take_halt = halt_i & ~siic_i & ~rti_i;
    assign redir     = siic_i | rti_i | (~halt_i & (jr_en_i | br_en_i));
    assign tgt = siic_i  ? EXC_VEC :
                 rti_i   ? epc_q :
                 jr_en_i ? rs_i + imm_i :
                           pc_inc + br_imm_i;
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                epc_d = siic_i ? pc_inc : epc_q;
                if (take_halt) begin
                    state_d = HALTED;
                    pend_d  = 1'b0;
                end else if (stall_i) begin
                    // youngest redirect during a stall overwrites the buffer
                    pend_d      = pend_q | redir;
                    pend_addr_d = redir ? tgt : pend_addr_q;
                end else begin
                    pc_d   = redir ? tgt : pend_q ? pend_addr_q : pc_inc;
                    pend_d = 1'b0;
                end
            end
            default: state_d = HALTED;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            epc_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end
    assign pc_o          = pc_q;
    assign pc_inc_o      = pc_inc;
    assign fetch_valid_o = state_q == RUN;
    assign halted_o      = state_q == HALTED;
    assign epc_o         = epc_q;
    assign redir_pend_o  = pend_q;
`ifdef PC_SEQ_ICNT_EN
    logic [31:0] icnt_q, icnt_d;
    // one fetch is issued on each running, unstalled, non-halting edge
    assign icnt_d = (state_q == RUN && !stall_i && !halt_i) ? icnt_q + 32'd1 : icnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) icnt_q <= '0;
        else         icnt_q <= icnt_d;
    end
    assign icnt_o = icnt_q;
`endif
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed-vector bench for pc_seq with a behavioural reference model.
module tb_pc_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, br_en = 1'b0, jr_en = 1'b0, halt = 1'b0, siic = 1'b0, rti = 1'b0;
    logic [15:0] br_imm = '0, rs = '0, imm = '0;
    logic [15:0] pc, pc_inc, epc;
    logic        fetch_valid, halted, redir_pend;
`ifdef PC_SEQ_ICNT_EN
    logic [31:0] icnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .br_en_i(br_en), .br_imm_i(br_imm),
        .jr_en_i(jr_en), .rs_i(rs), .imm_i(imm), .halt_i(halt), .siic_i(siic), .rti_i(rti),
        .pc_o(pc), .pc_inc_o(pc_inc), .fetch_valid_o(fetch_valid), .halted_o(halted),
        .epc_o(epc), .redir_pend_o(redir_pend)
`ifdef PC_SEQ_ICNT_EN
        , .icnt_o(icnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=boot, 1=running, 2=halted; arithmetic done in plain integers mod 2^16.
    int unsigned m_mode = 0, m_pc = 0, m_epc = 0, m_paddr = 0, m_icnt = 0;
    bit          m_pend = 0;
    always @(posedge clk or negedge rst_n) begin : model
        int unsigned seq, target;
        bit          wants;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_epc = 0; m_pend = 0; m_paddr = 0; m_icnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            seq    = (m_pc + 2) % 65536;
            wants  = 1;
            target = 0;
            if (siic)       begin target = 2; m_epc = seq; end
            else if (rti)   target = m_epc;
            else if (halt)  wants = 0;
            else if (jr_en) target = (rs + imm) % 65536;
            else if (br_en) target = (seq + br_imm) % 65536;
            else            wants = 0;
            if (!stall && !halt) m_icnt++;
            if (halt && !siic && !rti) begin
                m_mode = 2;
                m_pend = 0;
            end else if (stall) begin
                if (wants) begin m_pend = 1; m_paddr = target; end
            end else begin
                m_pc   = wants ? target : (m_pend ? m_paddr : seq);
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_inc", pc_inc, (m_pc + 2) % 65536);
        chk("fetch_valid", fetch_valid, m_mode == 1);
        chk("halted", halted, m_mode == 2);
        chk("epc", epc, m_epc);
        chk("redir_pend", redir_pend, m_pend);
`ifdef PC_SEQ_ICNT_EN
        chk("icnt", icnt, m_icnt);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // apply one cycle of inputs: stall, br_en, br_imm, jr_en, rs, imm, halt, siic, rti
    task automatic go(input logic s, input logic b, input logic [15:0] bi, input logic j,
                      input logic [15:0] r, input logic [15:0] i, input logic h,
                      input logic x, input logic t);
        stall = s; br_en = b; br_imm = bi; jr_en = j; rs = r; imm = i; halt = h; siic = x; rti = t;
        tick();
        stall = 0; br_en = 0; br_imm = 0; jr_en = 0; rs = 0; imm = 0; halt = 0; siic = 0; rti = 0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_fv", fetch_valid, 1'b0);
        chk("rst_pend", redir_pend, 1'b0);
        rst_n = 1'b1;
        chk("boot_fv", fetch_valid, 1'b0);
        tick(); chk("seq0", pc, 16'h0000); chk("seq0_fv", fetch_valid, 1'b1);
        tick(); chk("seq2", pc, 16'h0002);
        tick(); chk("seq4", pc, 16'h0004);
        tick(); chk("seq6", pc, 16'h0006);
        go(0, 0, 0, 1, 16'h0010, 0, 0, 0, 0);             chk("jr_10", pc, 16'h0010);
        go(0, 1, 16'hFFF8, 0, 0, 0, 0, 0, 0);             chk("br_back", pc, 16'h000A);
        go(0, 1, 16'h0040, 1, 16'h0100, 16'h0004, 0, 0, 0); chk("jr_over_br", pc, 16'h0104);
        go(0, 0, 0, 1, 16'h0020, 0, 0, 0, 0);             chk("jr_20", pc, 16'h0020);
        go(0, 0, 0, 0, 0, 0, 0, 1, 0);                    chk("siic_pc", pc, 16'h0002); chk("siic_epc", epc, 16'h0022);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0);                    chk("post_exc", pc, 16'h0004);
        go(0, 0, 0, 0, 0, 0, 0, 0, 1);                    chk("rti_pc", pc, 16'h0022);
        go(0, 0, 0, 1, 16'h0040, 0, 0, 0, 0);             chk("jr_40", pc, 16'h0040);
        go(1, 1, 16'h003E, 0, 0, 0, 0, 0, 0);             chk("stall1_pc", pc, 16'h0040); chk("stall1_pend", redir_pend, 1'b1);
        go(1, 0, 0, 1, 16'h0200, 0, 0, 0, 0);             chk("stall2_pc", pc, 16'h0040); chk("stall2_pend", redir_pend, 1'b1);
        go(1, 0, 0, 0, 0, 0, 0, 0, 0);                    chk("stall3_pc", pc, 16'h0040);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0);                    chk("release_pc", pc, 16'h0200); chk("release_pend", redir_pend, 1'b0);
        go(1, 0, 0, 1, 16'h0300, 0, 0, 0, 0);             chk("stall_jr_pc", pc, 16'h0200);
        go(0, 1, 16'h0010, 0, 0, 0, 0, 0, 0);             chk("new_over_pend", pc, 16'h0212); chk("new_pend_clr", redir_pend, 1'b0);
        go(1, 0, 0, 0, 0, 0, 0, 1, 0);                    chk("stall_siic_pc", pc, 16'h0212); chk("stall_siic_epc", epc, 16'h0214);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0);                    chk("stall_siic_rel", pc, 16'h0002);
        go(0, 0, 0, 0, 0, 0, 1, 1, 0);                    chk("siic_over_halt", halted, 1'b0); chk("siic_halt_epc", epc, 16'h0004);
        go(0, 0, 0, 1, 16'h0030, 0, 0, 0, 0);             chk("jr_30", pc, 16'h0030);
        go(1, 1, 16'h0000, 0, 0, 0, 0, 0, 0);             chk("pre_halt_pend", redir_pend, 1'b1);
        go(1, 0, 0, 0, 0, 0, 1, 0, 0);                    chk("halt_on", halted, 1'b1); chk("halt_pend_clr", redir_pend, 1'b0);
        for (int k = 0; k < 10; k++) begin
            go(0, 1, 16'h0100, 0, 0, 0, 0, k[0], 0);
            chk("halt_pc", pc, 16'h0030);
            chk("halt_fv", fetch_valid, 1'b0);
        end
        chk("halt_epc", epc, 16'h0004);
        #1 rst_n = 1'b0;
        #1 chk("arst_pc", pc, 16'h0000); chk("arst_halted", halted, 1'b0);
        tick(); rst_n = 1'b1;
        tick();                                           chk("reboot_pc", pc, 16'h0000);
        go(0, 0, 0, 1, 16'hFFFE, 0, 0, 0, 0);             chk("top_pc", pc, 16'hFFFE); chk("top_inc", pc_inc, 16'h0000);
        go(0, 0, 0, 0, 0, 0, 0, 0, 0);                    chk("wrap_pc", pc, 16'h0000);
        go(0, 0, 0, 0, 0, 0, 0, 1, 1);                    chk("siic_rti_pc", pc, 16'h0002); chk("siic_rti_epc", epc, 16'h0002);
        go(0, 0, 0, 0, 0, 0, 0, 0, 1);                    chk("rti2_pc", pc, 16'h0002);
        go(1, 1, 16'h0010, 0, 0, 0, 0, 0, 0);             chk("pend_before_rst", redir_pend, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("arst_pend", redir_pend, 1'b0); chk("arst_pc2", pc, 16'h0000);
        tick(); rst_n = 1'b1;
        repeat (3) tick();
        chk("final_pc", pc, 16'h0004);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Generalises address width, increment size, reset and exception vectors.
- Adds fetch stall with a buffered pending redirect, a persistent halted state, exception entry with EPC save, and return-from-exception.
- Sits between the control/decode redirect logic and instruction memory; drives the fetch address every cycle.

Parameters:
AW, 16, address/PC width in bits
INC, 2, sequential increment in bytes
RESET_VEC, 0, PC value loaded on reset
EXC_VEC, 2, PC target on exception (SIIC)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  fetch hold; PC must not advance
br_en  in  1  PC-relative branch/jump taken
br_imm  in  AW  sign-extended branch displacement (caller extends)
jr_en  in  1  register-indirect jump taken
rs  in  AW  register base for jr
imm  in  AW  sign-extended offset for jr
halt  in  1  enter halted state
siic  in  1  exception request
rti  in  1  return from exception
pc  out  AW  current fetch address (registered)
pc_inc  out  AW  pc + INC
fetch_valid  out  1  pc is a valid fetch address this cycle
halted  out  1  block is in HALTED
epc  out  AW  saved exception return address
redir_pend  out  1  a redirect is buffered awaiting stall release

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VEC, epc=0, state=BOOT, pend=0.
  - All outputs derive from these values: fetch_valid=0, halted=0, redir_pend=0.
- States:
  - BOOT: one cycle with fetch_valid=0, then unconditionally to RUN; pc holds.
  - RUN: fetch_valid=1.
  - HALTED: fetch_valid=0, halted=1, pc frozen. Only reset leaves HALTED; all inputs are ignored.
- Arithmetic: all sums are modulo 2^AW; wrap-around is silent (pc=2^AW-INC → pc_inc=0).
- Redirect selection in RUN, priority highest first:
  - siic → target EXC_VEC; epc ← pc_inc on the same edge.
  - rti → target epc.
  - halt → go to HALTED; pc holds.
  - jr_en → target rs+imm.
  - br_en → target pc_inc+br_imm.
  - otherwise → target pc_inc.
- Pending-redirect buffer:
  - A redirect (siic, rti, jr_en or br_en) while stall=1 latches the target into pend_addr and sets pend=1. pc holds.
  - siic side effects (epc) still apply immediately.
  - A later redirect while pend=1 and stall=1 overwrites pend_addr (the youngest redirect wins).
  - When stall=0 and pend=1 with no new redirect: pc ← pend_addr and pend clears. A new redirect in that same cycle takes precedence over pend_addr and clears pend.
  - halt while stall=1 still enters HALTED next edge and clears pend.
- stall=1 with no redirect: pc holds, pend unchanged.
- Latency:
  - All redirects take effect on pc one clock edge after they are sampled, when stall=0.
  - pc_inc is combinational from pc.
- siic and rti asserted together: siic wins; epc is updated and rti is dropped.
- Reset asserted mid-stall or mid-pending: all state is cleared asynchronously and the pending redirect is lost.

Optional Feature:
- Macro: PC_SEQ_ICNT_EN.
- Defined:
  - Adds output icnt [31:0], reset to 0.
  - Increments by 1 on every edge where state=RUN, stall=0 and halt=0 (one fetch issued).
  - Wraps at 2^32. Frozen in HALTED.
- Undefined: no icnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset release, AW=16, RESET_VEC=0: cycle0 fetch_valid=0; then pc sequence 0,2,4,6 with fetch_valid=1.
- pc=0x0010, br_en=1, br_imm=0xFFF8 → next pc=0x000A. jr_en=1 with br_en=1, rs=0x0100, imm=0x0004 → pc=0x0104.
- pc=0x0020, siic=1 → pc=EXC_VEC=0x0002, epc=0x0022. Later rti=1 → pc=0x0022.
- stall=1 for 3 cycles at pc=0x0040, with br_en (target 0x0080) in cycle 1 and jr_en (target 0x0200) in cycle 2 → pc stays 0x0040 and redir_pend=1. First cycle with stall=0 → pc=0x0200, redir_pend=0.
- halt=1 at pc=0x0030 → halted=1, fetch_valid=0, pc=0x0030 held for 10 cycles despite br_en/siic. rst low → pc=RESET_VEC, halted=0.
- pc=0xFFFE → next pc=0x0000 (wrap). With PC_SEQ_ICNT_EN: icnt counts issued fetches only and excludes stalled and halted cycles.
